// File: rtl/i2c_slave.sv
// I2C target with a 7-bit address: START/STOP detection, address ACK, write delivery and read shift-out.
// Optional SCL clock stretching on reads is enabled by defining I2C_SLAVE_STRETCH_EN (adds dat_vld).
module i2c_slave #(
    parameter logic [6:0] ADDR = 7'h50,
    parameter int         US   = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sda,
    output logic       sda_out,
    input  logic       scl,
    output logic       scl_out,
    input  logic [7:0] dat,
`ifdef I2C_SLAVE_STRETCH_EN
    input  logic       dat_vld,
`endif
    output logic [7:0] dat_out,
    output logic       wr_vld,
    output logic       rd_req,
    input  logic       nack_wr,
    output logic       sta,
    output logic       sto,
    output logic       sel
);

    typedef enum logic [2:0] {
        ST_IDLE, ST_ADDR, ST_AACK, ST_WRX, ST_WACK, ST_RTX, ST_RACK, ST_WAIT
    } state_t;

    state_t     state;
    logic [2:0] scl_p, sda_p;   // [1:0] synchroniser, [2] previous value for edge detection
    logic [2:0] cnt;
    logic [6:0] sr;
    logic [6:0] tx;
    logic       rw, ph, nack_l;

    always_ff @(posedge clk) begin
        if (rst) begin
            scl_p <= 3'b111;
            sda_p <= 3'b111;
        end else begin
            scl_p <= {scl_p[1:0], scl};
            sda_p <= {sda_p[1:0], sda};
        end
    end

    logic sda_s, scl_rise, scl_fall, start_ev, stop_ev, load_rd;
    assign sda_s    = sda_p[1];
    assign scl_rise = scl_p[1] & ~scl_p[2];
    assign scl_fall = ~scl_p[1] & scl_p[2];
    // SCL must be stably high across the SDA edge so a simultaneous release after reset is not a START
    assign start_ev = sda_p[2] & ~sda_p[1] & scl_p[1] & scl_p[2];
    assign stop_ev  = ~sda_p[2] & sda_p[1] & scl_p[1] & scl_p[2];
    // a fall in RACK can only follow a master ACK, since a NACK leaves RACK on the rise
    assign load_rd  = scl_fall & ((state == ST_AACK & ph & rw) | (state == ST_RACK));

`ifdef I2C_SLAVE_STRETCH_EN
    localparam int TSU = 47 * US / 10;
    logic        str;
    logic [15:0] tsu_cnt;
`else
    logic unused_us;
    assign unused_us = (US > 0);
    assign scl_out   = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            cnt     <= 3'd0;
            sr      <= 7'd0;
            tx      <= 7'd0;
            rw      <= 1'b0;
            ph      <= 1'b0;
            nack_l  <= 1'b0;
            sda_out <= 1'b1;
            dat_out <= 8'd0;
            wr_vld  <= 1'b0;
            rd_req  <= 1'b0;
            sta     <= 1'b0;
            sto     <= 1'b0;
            sel     <= 1'b0;
`ifdef I2C_SLAVE_STRETCH_EN
            scl_out <= 1'b1;
            str     <= 1'b0;
            tsu_cnt <= 16'd0;
`endif
        end else begin
            wr_vld <= 1'b0;
            rd_req <= 1'b0;
            sta    <= 1'b0;
            sto    <= 1'b0;
            if (stop_ev) begin
                state   <= ST_IDLE;
                sda_out <= 1'b1;
                sel     <= 1'b0;
                sto     <= 1'b1;
`ifdef I2C_SLAVE_STRETCH_EN
                scl_out <= 1'b1;
                str     <= 1'b0;
                tsu_cnt <= 16'd0;
`endif
            end else if (start_ev) begin
                state   <= ST_ADDR;
                cnt     <= 3'd7;
                sda_out <= 1'b1;
                sel     <= 1'b0;
                sta     <= 1'b1;
`ifdef I2C_SLAVE_STRETCH_EN
                scl_out <= 1'b1;
                str     <= 1'b0;
                tsu_cnt <= 16'd0;
            end else if (str) begin
                if (dat_vld) begin
                    str     <= 1'b0;
                    tx      <= dat[6:0];
                    sda_out <= dat[7];
                    cnt     <= 3'd7;
                    tsu_cnt <= 16'(TSU);
                    if (TSU == 0) scl_out <= 1'b1;
                end else begin
                    rd_req <= 1'b1;
                end
            end else if (tsu_cnt != 16'd0) begin
                if (tsu_cnt == 16'd1) scl_out <= 1'b1;
                tsu_cnt <= tsu_cnt - 16'd1;
`endif
            end else begin
                case (state)
                    ST_ADDR: if (scl_rise) begin
                        sr  <= {sr[5:0], sda_s};
                        cnt <= cnt - 3'd1;
                        if (cnt == 3'd0) begin
                            ph <= 1'b0;
                            rw <= sda_s;
                            state <= (sr == ADDR) ? ST_AACK : ST_WAIT;
                        end
                    end
                    ST_AACK: if (scl_fall) begin
                        if (!ph) begin
                            sda_out <= 1'b0;
                            sel     <= 1'b1;
                            ph      <= 1'b1;
                        end else begin
                            sda_out <= 1'b1;
                            ph      <= 1'b0;
                            if (!rw) begin
                                state <= ST_WRX;
                                cnt   <= 3'd7;
                            end
                        end
                    end
                    ST_WRX: if (scl_rise) begin
                        sr  <= {sr[5:0], sda_s};
                        cnt <= cnt - 3'd1;
                        if (cnt == 3'd0) begin
                            dat_out <= {sr, sda_s};
                            nack_l  <= nack_wr;
                            ph      <= 1'b0;
                            state   <= ST_WACK;
                        end
                    end
                    ST_WACK: if (scl_fall) begin
                        if (!ph) begin
                            sda_out <= nack_l;
                            wr_vld  <= ~nack_l;
                            ph      <= 1'b1;
                        end else begin
                            sda_out <= 1'b1;
                            ph      <= 1'b0;
                            cnt     <= 3'd7;
                            state   <= nack_l ? ST_WAIT : ST_WRX;
                        end
                    end
                    ST_RTX: if (scl_fall) begin
                        if (cnt == 3'd0) begin
                            sda_out <= 1'b1;
                            state   <= ST_RACK;
                        end else begin
                            sda_out <= tx[6];
                            tx      <= {tx[5:0], 1'b0};
                            cnt     <= cnt - 3'd1;
                        end
                    end
                    ST_RACK: if (scl_rise && sda_s) begin
                        sel   <= 1'b0;
                        state <= ST_WAIT;
                    end
                    ST_WAIT: sda_out <= 1'b1;
                    default: ;
                endcase
                if (load_rd) begin
                    state  <= ST_RTX;
                    rd_req <= 1'b1;
`ifdef I2C_SLAVE_STRETCH_EN
                    str     <= 1'b1;
                    scl_out <= 1'b0;
                    sda_out <= 1'b1;
`else
                    tx      <= dat[6:0];
                    sda_out <= dat[7];
                    cnt     <= 3'd7;
`endif
                end
            end
        end
    end

endmodule
